// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to a variable-latency instruction
// memory, buffers returned words with their PCs in an in-order FIFO and hands them to decode
// over valid/ready. A redirect flushes the queue and discards in-flight responses.
// Optional: define IFQ_PERF_EN to add saturating perf counters (fetched/flushed/starve).
module instruction_fetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
`ifdef IFQ_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed,
   output logic [31:0] perf_starve,
`endif
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0] NOP = 32'h00000013;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] drop_q, drop_d;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem [DEPTH];
   logic          credit_ok, accept, push, pop, drop_resp;

   // Request credit, handshakes and head-of-queue outputs
   always_comb begin
      // Reserve a FIFO slot for every outstanding request so responses can never overflow
      credit_ok = ((32'(count_q) + 32'(outst_q)) < DEPTH) &&
                  (32'(outst_q) < MAX_OUTSTANDING) && (drop_q == '0);
      imem_req_valid = !reset && !redirect_valid && credit_ok;
      imem_req_addr  = fetch_pc_q;
      accept         = imem_req_valid && imem_req_ready;
      push           = imem_resp_valid && !redirect_valid && (drop_q == '0);
      drop_resp      = imem_resp_valid && !redirect_valid && (drop_q != '0);
      out_valid      = (count_q != '0);
      pop            = out_valid && out_ready && !redirect_valid;
      out_instr      = out_valid ? instr_mem[rd_ptr_q] : NOP;
      out_pc         = out_valid ? pc_mem[rd_ptr_q] : 32'h0;
   end

   // Next-state: redirect overrides accept/push/pop for the cycle
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         resp_pc_d  = redirect_pc & ~32'h3;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         // A response arriving now is discarded and retires one of the outstanding requests
         outst_d    = outst_q - OW'(imem_resp_valid);
         drop_d     = outst_q - OW'(imem_resp_valid);
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            resp_pc_d = resp_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         if (drop_resp) drop_d = drop_q - OW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         outst_d = outst_q + OW'(accept) - OW'(imem_resp_valid);
      end
   end

   // Control state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   // FIFO storage; contents are qualified by count so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_resp_data;
         pc_mem[wr_ptr_q]    <= resp_pc_q;
      end
   end

`ifdef IFQ_PERF_EN
   logic [31:0] flush_inc;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hffffffff : s[31:0];
   endfunction

   // Flushed = entries cleared by redirect plus every response discarded because of one
   always_comb begin
      flush_inc = redirect_valid ? (32'(count_q) + 32'(imem_resp_valid)) : 32'(drop_resp);
   end

   // Saturating performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
         perf_starve  <= '0;
      end else begin
         perf_fetched <= sat_add(perf_fetched, 32'(push));
         perf_flushed <= sat_add(perf_flushed, flush_inc);
         perf_starve  <= sat_add(perf_starve, 32'(!out_valid));
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: an in-order memory model plus a queue-based reference
// of the fetch queue; scenario tasks compare DUT outputs against it.
module tb_instruction_fetch_queue;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;
   localparam logic [31:0] RPC = 32'h00000000;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   logic reset;
   logic redirect_valid, imem_req_ready, imem_resp_valid, out_ready;
   logic [31:0] redirect_pc, imem_resp_data;
   logic imem_req_valid, out_valid;
   logic [31:0] imem_req_addr, out_instr, out_pc;
`ifdef IFQ_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, perf_starve;
`endif

   always #5 clk = ~clk;

   instruction_fetch_queue #(
      .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef IFQ_PERF_EN
      .perf_fetched(perf_fetched),
      .perf_flushed(perf_flushed),
      .perf_starve(perf_starve),
`endif
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc)
   );

   typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
   typedef struct {logic [31:0] addr; int due;} req_t;

   ent_t mq[$];
   req_t pend[$];
   logic [31:0] m_fetch, m_resp;
   int m_outst, m_drop, cyc, lat;
   logic exp_rv;
   int total = 0;
   int bad = 0;

   function automatic logic [31:0] img(input logic [31:0] a);
      return (a * 32'h9e3779b1) ^ 32'h5a5a0013;
   endfunction

   task automatic model_reset();
      mq.delete();
      pend.delete();
      m_fetch = RPC;
      m_resp  = RPC;
      m_outst = 0;
      m_drop  = 0;
   endtask

   // Drive the memory response for this cycle and derive the expected request valid
   task automatic settle(input bit resp_en);
      imem_resp_valid = resp_en && (pend.size() > 0) && (pend[0].due <= cyc);
      imem_resp_data  = imem_resp_valid ? img(pend[0].addr) : $urandom;
      exp_rv = !redirect_valid && ((mq.size() + m_outst) < DEPTH) && (m_outst < MAXO) &&
               (m_drop == 0);
      #1;
   endtask

   // Clock edge and reference update
   task automatic advance();
      bit acc, rv;
      logic [31:0] rd;
      ent_t e;
      req_t r;
      acc = exp_rv && imem_req_ready;
      rv  = imem_resp_valid;
      rd  = imem_resp_data;
      @(posedge clk);
      if (rv) void'(pend.pop_front());
      if (redirect_valid) begin
         mq.delete();
         m_fetch = redirect_pc & ~32'h3;
         m_resp  = redirect_pc & ~32'h3;
         m_drop  = m_outst - int'(rv);
         m_outst = m_outst - int'(rv);
      end else begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (rv) begin
            if (m_drop == 0) begin
               e.pc = m_resp;
               e.instr = rd;
               mq.push_back(e);
               m_resp = m_resp + 32'd4;
            end else m_drop--;
         end
         if (acc) begin
            r.addr = m_fetch;
            r.due  = cyc + lat;
            pend.push_back(r);
            m_fetch = m_fetch + 32'd4;
         end
         m_outst = m_outst + int'(acc) - int'(rv);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic cycle_once();
      settle(1'b1);
      advance();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (imem_req_valid !== 1'b0) begin bad++;
         $display("FAIL reset req_valid: got %b want 0", imem_req_valid); end
      total++; if (out_valid !== 1'b0) begin bad++;
         $display("FAIL reset out_valid: got %b want 0", out_valid); end
      total++; if (out_instr !== NOP) begin bad++;
         $display("FAIL reset out_instr: got %h want %h", out_instr, NOP); end
      total++; if (out_pc !== 32'h0) begin bad++;
         $display("FAIL reset out_pc: got %h want 0", out_pc); end
      total++; if (imem_req_addr !== RPC) begin bad++;
         $display("FAIL reset req_addr: got %h want %h", imem_req_addr, RPC); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_fill();
      int npop = 0;
      lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         settle(1'b1);
         total++; if (imem_req_valid !== exp_rv) begin bad++;
            $display("FAIL fill req_valid c%0d: got %b want %b", i, imem_req_valid, exp_rv); end
         total++; if (exp_rv && imem_req_addr !== m_fetch) begin bad++;
            $display("FAIL fill req_addr c%0d: got %h want %h", i, imem_req_addr, m_fetch); end
         total++; if (out_valid !== (mq.size() != 0)) begin bad++;
            $display("FAIL fill out_valid c%0d: got %b want %b", i, out_valid, mq.size() != 0); end
         if (mq.size() != 0) begin
            total++; if (out_pc !== 32'(4 * npop) || out_instr !== img(32'(4 * npop))) begin
               bad++;
               $display("FAIL fill head c%0d: got pc=%h instr=%h want pc=%h instr=%h", i,
                        out_pc, out_instr, 32'(4 * npop), img(32'(4 * npop)));
            end
            npop++;
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      bit seen = 1'b0;
      do_reset();
      lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         settle(1'b1);
         if (imem_req_valid && imem_req_ready) acc++;
         advance();
      end
      settle(1'b1);
      total++; if (acc != DEPTH) begin bad++;
         $display("FAIL bp req_count: got %0d want %0d", acc, DEPTH); end
      total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b1) begin bad++;
         $display("FAIL bp full: got req_valid=%b out_valid=%b want 0 1",
                  imem_req_valid, out_valid); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle(1'b1);
         if (i < 4) begin
            total++; if (out_pc !== 32'(4 * i) || out_instr !== img(32'(4 * i))) begin bad++;
               $display("FAIL bp order %0d: got pc=%h instr=%h want pc=%h", i, out_pc,
                        out_instr, 32'(4 * i)); end
         end
         if (!seen && imem_req_valid) begin
            seen = 1'b1;
            total++; if (imem_req_addr !== 32'h10) begin bad++;
               $display("FAIL bp resume_addr: got %h want 00000010", imem_req_addr); end
         end
         advance();
      end
      total++; if (!seen) begin bad++;
         $display("FAIL bp resume: got no request want request at 00000010"); end
   endtask

   task automatic test_stall();
      do_reset();
      lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
      cycle_once();
      cycle_once();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle(1'b1);
         total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++;
            $display("FAIL stall hold c%0d: got valid=%b addr=%h want 1 00000008", i,
                     imem_req_valid, imem_req_addr); end
         advance();
      end
      imem_req_ready = 1'b1;
      settle(1'b1);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++;
         $display("FAIL stall accept: got valid=%b addr=%h want 1 00000008",
                  imem_req_valid, imem_req_addr); end
      advance();
      settle(1'b1);
      total++; if (imem_req_addr !== 32'hc) begin bad++;
         $display("FAIL stall next_addr: got %h want 0000000c", imem_req_addr); end
      advance();
   endtask

   task automatic test_redirect();
      bit seen_req = 1'b0;
      bit seen_out = 1'b0;
      do_reset();
      lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
      cycle_once();
      cycle_once();
      redirect_valid = 1'b1; redirect_pc = 32'h00000103;
      settle(1'b1);
      total++; if (imem_req_valid !== 1'b0) begin bad++;
         $display("FAIL redir req_during: got %b want 0", imem_req_valid); end
      advance();
      redirect_valid = 1'b0;
      settle(1'b1);
      total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin bad++;
         $display("FAIL redir draining: got req_valid=%b out_valid=%b want 0 0",
                  imem_req_valid, out_valid); end
      advance();
      for (int i = 0; i < 20 && !seen_out; i++) begin
         settle(1'b1);
         if (!seen_req && imem_req_valid) begin
            seen_req = 1'b1;
            total++; if (imem_req_addr !== 32'h100) begin bad++;
               $display("FAIL redir req_addr: got %h want 00000100", imem_req_addr); end
         end
         if (out_valid) begin
            seen_out = 1'b1;
            total++; if (out_pc !== 32'h100 || out_instr !== img(32'h100)) begin bad++;
               $display("FAIL redir first_out: got pc=%h instr=%h want pc=00000100 instr=%h",
                        out_pc, out_instr, img(32'h100)); end
         end
         advance();
      end
      total++; if (!seen_out) begin bad++;
         $display("FAIL redir timeout: got no out_valid want out_valid within 20 cycles"); end
   endtask

   task automatic test_flush_full();
      int acc = 0;
      do_reset();
      lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) cycle_once();
      redirect_valid = 1'b1; redirect_pc = 32'h00000040; out_ready = 1'b1;
      settle(1'b1);
      total++; if (imem_resp_valid !== 1'b1 || out_valid !== 1'b1) begin bad++;
         $display("FAIL flush setup: got resp=%b out_valid=%b want 1 1",
                  imem_resp_valid, out_valid); end
      advance();
      redirect_valid = 1'b0; out_ready = 1'b0;
      settle(1'b1);
      total++; if (out_valid !== 1'b0) begin bad++;
         $display("FAIL flush empty: got out_valid=%b want 0", out_valid); end
      for (int i = 0; i < 10; i++) begin
         if (i > 0) settle(1'b1);
         if (imem_req_valid && imem_req_ready) acc++;
         advance();
      end
      settle(1'b1);
      total++; if (acc != DEPTH) begin bad++;
         $display("FAIL flush refill: got %0d requests want %0d", acc, DEPTH); end
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin bad++;
         $display("FAIL flush head: got valid=%b pc=%h want 1 00000040", out_valid, out_pc); end
      advance();
   endtask

   task automatic test_midreset();
      do_reset();
      lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 10 && mq.size() != 3; i++) cycle_once();
      settle(1'b1);
      total++; if (out_valid !== 1'b1) begin bad++;
         $display("FAIL midrst pre: got out_valid=%b want 1", out_valid); end
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin bad++;
         $display("FAIL midrst valids: got req=%b out=%b want 0 0", imem_req_valid, out_valid); end
      total++; if (out_instr !== NOP || out_pc !== 32'h0 || imem_req_addr !== RPC) begin bad++;
         $display("FAIL midrst values: got instr=%h pc=%h addr=%h want %h 0 %h",
                  out_instr, out_pc, imem_req_addr, NOP, RPC); end
`ifdef IFQ_PERF_EN
      total++; if (perf_fetched !== 0 || perf_flushed !== 0 || perf_starve !== 0) begin bad++;
         $display("FAIL midrst perf: got %0d %0d %0d want 0 0 0",
                  perf_fetched, perf_flushed, perf_starve); end
`endif
      @(negedge clk);
      reset = 1'b0;
      settle(1'b1);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin bad++;
         $display("FAIL midrst restart: got valid=%b addr=%h want 1 %h",
                  imem_req_valid, imem_req_addr, RPC); end
      advance();
   endtask

   task automatic test_random();
      logic [31:0] e_pc, e_instr;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         lat = int'($urandom_range(1, 3));
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = $urandom;
         imem_req_ready = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         settle($urandom_range(0, 3) != 0);
         e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
         e_instr = (mq.size() != 0) ? mq[0].instr : NOP;
         total++; if (imem_req_valid !== exp_rv || (exp_rv && imem_req_addr !== m_fetch)) begin
            bad++;
            $display("FAIL rand req c%0d: got valid=%b addr=%h want valid=%b addr=%h", i,
                     imem_req_valid, imem_req_addr, exp_rv, m_fetch);
         end
         total++; if (out_valid !== (mq.size() != 0) || out_pc !== e_pc ||
                      out_instr !== e_instr) begin
            bad++;
            $display("FAIL rand out c%0d: got v=%b pc=%h instr=%h want v=%b pc=%h instr=%h", i,
                     out_valid, out_pc, out_instr, mq.size() != 0, e_pc, e_instr);
         end
         advance();
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = 32'h0;
      out_ready = 1'b0;
      cyc = 0;
      lat = 1;
      exp_rv = 1'b0;
      model_reset();
      test_reset();
      test_fill();
      test_backpressure();
      test_stall();
      test_redirect();
      test_flush_full();
      test_midreset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
